// File: rtl/generic_spi_shift_engine.sv
// SPI mode-0 controller shift engine, MSB first, with valid/ready word streams.
// SCLK is divided down from axi_clk; every output is registered.
module generic_spi_shift_engine #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CLK_DIV_WIDTH = 8,
    parameter int unsigned LEN_WIDTH     = 16
) (
    input  logic                     axi_clk,
    input  logic                     axi_resetn,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     trans_len,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic [DATA_WIDTH-1:0]    tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     sclk,
    output logic                     cs_b,
    output logic                     pico,
    input  logic                     poci
);

    localparam int unsigned BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;
    localparam logic [2:0] ST_TRAIL = 3'd5;

    logic [2:0]               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cs_b_q, cs_b_d;
    logic                     sclk_q, sclk_d;
    logic                     pico_q, pico_d;
    logic                     tx_ready_q, tx_ready_d;
    logic                     rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
    logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
    logic [CLK_DIV_WIDTH-1:0] half_cnt_q, half_cnt_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     word_cnt_q, word_cnt_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]    tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]    rx_shift_q, rx_shift_d;
    logic                     half_done;

    assign half_done = (half_cnt_q == div_q);

    // State register with synchronous reset; a reset mid-transfer aborts without done.
    always_ff @(posedge axi_clk) begin
        if (!axi_resetn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_b_q     <= 1'b1;
            sclk_q     <= 1'b0;
            pico_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            div_q      <= '0;
            half_cnt_q <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_b_q     <= cs_b_d;
            sclk_q     <= sclk_d;
            pico_q     <= pico_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            div_q      <= div_d;
            half_cnt_q <= half_cnt_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_b_d     = cs_b_q;
        sclk_d     = sclk_q;
        pico_d     = pico_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        div_d      = div_q;
        half_cnt_d = half_cnt_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (trans_len != '0) begin
                        state_d    = ST_LEAD;
                        busy_d     = 1'b1;
                        cs_b_d     = 1'b0;
                        div_d      = clk_div;
                        len_d      = trans_len;
                        word_cnt_d = '0;
                        half_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                if (half_done) begin
                    half_cnt_d = '0;
                    tx_ready_d = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    half_cnt_d = half_cnt_q + CLK_DIV_WIDTH'(1);
                end
            end
            ST_LOAD: begin
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    pico_d     = tx_data[DATA_WIDTH-1];
                    tx_ready_d = 1'b0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!half_done) begin
                    half_cnt_d = half_cnt_q + CLK_DIV_WIDTH'(1);
                end else begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    if (!sclk_q) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], poci};
                    end else if (bit_cnt_q == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        // Last falling edge: word complete, pico keeps the last bit.
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_PUSH;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_WIDTH'(1);
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        pico_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end
            end
            ST_PUSH: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
                    half_cnt_d = '0;
                    if (word_cnt_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = ST_TRAIL;
                    end else begin
                        tx_ready_d = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_TRAIL: begin
                if (half_done) begin
                    half_cnt_d = '0;
                    cs_b_d     = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pico_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    half_cnt_d = half_cnt_q + CLK_DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sclk     = sclk_q;
    assign cs_b     = cs_b_q;
    assign pico     = pico_q;

endmodule

// File: tb/tb_generic_spi_shift_engine.sv
// Bench for generic_spi_shift_engine: vector table, random transactions and a
// mode-0 peripheral model that supplies poci and captures pico word by word.
module tb_generic_spi_shift_engine;

    localparam int unsigned W    = 32;
    localparam int          LIM  = 20000;

    typedef struct packed {
        logic [7:0]        div;
        logic [2:0]        len;
        logic [3:0][31:0]  tx;
        logic [3:0][31:0]  resp;
        logic [3:0][31:0]  exp_rx;
        logic              loop;
        logic [4:0]        rx_stall;
        logic [3:0]        tx_delay;
        logic              dup;
    } rec_t;

    logic        axi_clk = 1'b0;
    logic        axi_resetn;
    logic        start;
    logic [15:0] trans_len;
    logic [7:0]  clk_div;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        cs_b;
    logic        pico;
    logic        poci;

    int total = 0;
    int bad   = 0;

    // Peripheral model / monitor state
    logic             loopback = 1'b0;
    logic [3:0][31:0] resp_w   = '0;
    int               cur_h    = 1;
    logic             poci_m   = 1'b0;
    int               rises = 0, done_cnt = 0, cs_fall = 0, cs_rise = 0, hp_err = 0, cs_err = 0;
    int               bitidx = 0, wordk = 0, phase_cnt = 0;
    logic             sclk_prev = 1'b0, cs_prev = 1'b1;
    logic [31:0]      cap = '0;
    logic [31:0]      cap_q[$];

    assign poci = loopback ? pico : poci_m;

    always #5 axi_clk = ~axi_clk;

    generic_spi_shift_engine dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn), .start(start), .trans_len(trans_len),
        .clk_div(clk_div), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .done(done),
        .sclk(sclk), .cs_b(cs_b), .pico(pico), .poci(poci)
    );

    // Mode-0 peripheral: captures pico on sclk rise, presents the next poci bit after each fall.
    always @(negedge axi_clk) begin
        if (!axi_resetn) begin
            bitidx    = 0;
            wordk     = 0;
            phase_cnt = 0;
        end else begin
            if (done) done_cnt++;
            if (sclk && cs_b) cs_err++;
            if (!cs_b && cs_prev) begin
                cs_fall++;
                bitidx = 0;
                wordk  = 0;
            end
            if (cs_b && !cs_prev) cs_rise++;
            if (sclk && !sclk_prev) begin
                rises++;
                cap = {cap[30:0], pico};
                if (bitidx != 0 && phase_cnt != cur_h) hp_err++;
                phase_cnt = 1;
            end else if (!sclk && sclk_prev) begin
                if (phase_cnt != cur_h) hp_err++;
                phase_cnt = 1;
                bitidx++;
                if (bitidx == W) begin
                    cap_q.push_back(cap);
                    bitidx = 0;
                    wordk++;
                end
            end else begin
                phase_cnt++;
            end
        end
        sclk_prev = sclk;
        cs_prev   = cs_b;
        poci_m    = (wordk < 4) ? resp_w[wordk][W-1-bitidx] : 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_trans(input rec_t r, input string tag);
        int          n;
        int          b_rises, b_done, b_fall, b_rise, b_hp, b_cs, b_cap;
        int          stall_err;
        int          t;
        logic [31:0] got [4];
        n         = int'(r.len);
        stall_err = 0;
        cur_h     = int'(r.div) + 1;
        loopback  = r.loop;
        resp_w    = r.resp;
        b_rises = rises; b_done = done_cnt; b_fall = cs_fall; b_rise = cs_rise;
        b_hp = hp_err; b_cs = cs_err; b_cap = cap_q.size();
        for (int i = 0; i < 4; i++) got[i] = '0;

        @(negedge axi_clk);
        start = 1'b1; trans_len = 16'(n); clk_div = r.div;
        @(negedge axi_clk);
        start = 1'b0;
        chk({tag, " busy_after_start"}, {62'd0, busy, cs_b}, 64'd2);

        fork
            begin : driver
                for (int k = 0; k < n; k++) begin
                    int tw = 0;
                    while (!tx_ready && tw < LIM) begin @(negedge axi_clk); tw++; end
                    if (!tx_ready) begin
                        chk({tag, " tx_ready_timeout"}, 64'd0, 64'd1);
                        break;
                    end
                    for (int d = 0; d < int'(r.tx_delay); d++) begin
                        @(negedge axi_clk);
                        if (sclk || cs_b || !tx_ready) stall_err++;
                    end
                    tx_valid = 1'b1; tx_data = r.tx[k];
                    @(negedge axi_clk);
                    tx_valid = 1'b0;
                end
            end
            begin : consumer
                for (int k = 0; k < n; k++) begin
                    int          tw = 0;
                    logic [31:0] hold;
                    while (!rx_valid && tw < LIM) begin @(negedge axi_clk); tw++; end
                    if (!rx_valid) begin
                        chk({tag, " rx_valid_timeout"}, 64'd0, 64'd1);
                        break;
                    end
                    hold = rx_data;
                    for (int s = 0; s < int'(r.rx_stall); s++) begin
                        @(negedge axi_clk);
                        if (!rx_valid || rx_data !== hold || sclk || cs_b) stall_err++;
                    end
                    rx_ready = 1'b1;
                    got[k]   = rx_data;
                    @(negedge axi_clk);
                    rx_ready = 1'b0;
                end
            end
            begin : dup_start
                if (r.dup) begin
                    int tw = 0;
                    while ((rises - b_rises) < 5 && tw < LIM) begin @(negedge axi_clk); tw++; end
                    start = 1'b1; trans_len = 16'd7;
                    @(negedge axi_clk);
                    start = 1'b0;
                end
            end
        join

        t = 0;
        while (!done && t < 200) begin @(negedge axi_clk); t++; end
        chk({tag, " done_seen"}, {63'd0, done}, 64'd1);
        chk({tag, " idle_at_done"}, {62'd0, busy, cs_b}, 64'd1);
        repeat (3) @(negedge axi_clk);

        for (int k = 0; k < n; k++)
            chk($sformatf("%s rx_word%0d", tag, k), 64'(got[k]), 64'(r.exp_rx[k]));
        chk({tag, " cap_count"}, 64'(cap_q.size() - b_cap), 64'(n));
        for (int k = 0; k < n && (b_cap + k) < cap_q.size(); k++)
            chk($sformatf("%s pico_word%0d", tag, k), 64'(cap_q[b_cap+k]), 64'(r.tx[k]));
        chk({tag, " sclk_rises"}, 64'(rises - b_rises), 64'(W * n));
        chk({tag, " done_pulses"}, 64'(done_cnt - b_done), 64'd1);
        chk({tag, " half_period_err"}, 64'(hp_err - b_hp), 64'd0);
        chk({tag, " cs_edges"}, {32'(cs_fall - b_fall), 32'(cs_rise - b_rise)}, {32'd1, 32'd1});
        chk({tag, " sclk_while_cs_high"}, 64'(cs_err - b_cs), 64'd0);
        chk({tag, " stall_err"}, 64'(stall_err), 64'd0);
    endtask

    rec_t tbl [5];
    rec_t rr;

    initial begin
        int b_done, b_fall, t;

        tbl[0] = '0; tbl[0].div = 8'd0; tbl[0].len = 3'd1; tbl[0].loop = 1'b1;
        tbl[0].tx[0] = 32'hA5A50F0F; tbl[0].exp_rx[0] = 32'hA5A50F0F;
        tbl[1] = '0; tbl[1].div = 8'd3; tbl[1].len = 3'd3;
        tbl[1].tx[0] = 32'h00000001; tbl[1].tx[1] = 32'h80000000; tbl[1].tx[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tbl[1].resp[i] = 32'hDEADBEEF; tbl[1].exp_rx[i] = 32'hDEADBEEF;
        end
        tbl[2] = '0; tbl[2].div = 8'd1; tbl[2].len = 3'd2; tbl[2].rx_stall = 5'd10; tbl[2].tx_delay = 4'd5;
        tbl[2].tx[0] = 32'h12345678; tbl[2].tx[1] = 32'h9ABCDEF0;
        tbl[2].resp[0] = 32'hCAFEF00D; tbl[2].resp[1] = 32'h0F0F0F0F;
        tbl[2].exp_rx[0] = 32'hCAFEF00D; tbl[2].exp_rx[1] = 32'h0F0F0F0F;
        tbl[3] = '0; tbl[3].div = 8'd0; tbl[3].len = 3'd2; tbl[3].dup = 1'b1;
        tbl[3].tx[0] = 32'hFFFF0000; tbl[3].tx[1] = 32'h0000FFFF;
        tbl[3].resp[0] = 32'h5A5A5A5A; tbl[3].resp[1] = 32'h00000001;
        tbl[3].exp_rx[0] = 32'h5A5A5A5A; tbl[3].exp_rx[1] = 32'h00000001;
        tbl[4] = '0; tbl[4].div = 8'd2; tbl[4].len = 3'd1;
        tbl[4].tx[0] = 32'h00000000; tbl[4].resp[0] = 32'hFFFFFFFF; tbl[4].exp_rx[0] = 32'hFFFFFFFF;

        axi_resetn = 1'b0; start = 1'b0; trans_len = '0; clk_div = '0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge axi_clk);
        chk("reset_outputs", {57'd0, sclk, cs_b, pico, tx_ready, rx_valid, busy, done}, 64'h20);
        chk("reset_rx_data", 64'(rx_data), 64'd0);
        axi_resetn = 1'b1;
        repeat (2) @(negedge axi_clk);

        for (int i = 0; i < 5; i++) run_trans(tbl[i], $sformatf("vec%0d", i));

        // Zero-length transaction: done next cycle, bus untouched.
        b_fall = cs_fall;
        start = 1'b1; trans_len = 16'd0; clk_div = 8'd1;
        @(negedge axi_clk);
        start = 1'b0;
        chk("len0_done", {61'd0, done, busy, cs_b}, 64'h5);
        @(negedge axi_clk);
        chk("len0_done_clears", {63'd0, done}, 64'd0);
        repeat (4) @(negedge axi_clk);
        chk("len0_no_cs_fall", 64'(cs_fall - b_fall), 64'd0);

        // Reset at bit 12 of word 0: bus aborted, no done pulse.
        cur_h = 1; loopback = 1'b1;
        start = 1'b1; trans_len = 16'd2; clk_div = 8'd0;
        @(negedge axi_clk);
        start = 1'b0;
        t = 0;
        while (!tx_ready && t < 100) begin @(negedge axi_clk); t++; end
        tx_valid = 1'b1; tx_data = 32'h3C3C3C3C;
        @(negedge axi_clk);
        tx_valid = 1'b0;
        t = 0;
        b_done = done_cnt;
        while ((rises % W) != 12 && t < 200) begin @(negedge axi_clk); t++; end
        chk("rst_reached_bit12", 64'(rises % W), 64'd12);
        axi_resetn = 1'b0;
        @(negedge axi_clk);
        chk("rst_mid_bus", {60'd0, cs_b, sclk, busy, done}, 64'h8);
        chk("rst_mid_streams", {62'd0, tx_ready, rx_valid}, 64'd0);
        axi_resetn = 1'b1;
        repeat (20) @(negedge axi_clk);
        chk("rst_no_done", {32'(done_cnt - b_done), 31'd0, busy}, 64'd0);
        run_trans(tbl[4], "after_rst");

        // Random transactions against the peripheral model.
        for (int i = 0; i < 12; i++) begin
            rr          = '0;
            rr.div      = 8'($urandom_range(0, 2));
            rr.len      = 3'($urandom_range(1, 4));
            rr.loop     = 1'($urandom_range(0, 1));
            rr.rx_stall = 5'($urandom_range(0, 6));
            rr.tx_delay = 4'($urandom_range(0, 4));
            rr.dup      = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                rr.tx[k]     = $urandom;
                rr.resp[k]   = $urandom;
                rr.exp_rx[k] = rr.loop ? rr.tx[k] : rr.resp[k];
            end
            run_trans(rr, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
